// File: rtl/aes_v3_multicycle.sv
// Multi-cycle AES SubBytes / MixColumn ISE unit that reuses SBOX_LANES S-boxes and MIX_LANES column engines.
// Optional feature macro: AES_V3_DECRYPT_EN builds the inverse S-box and {e,b,d,9} MixColumn engines.
module aes_v3_multicycle #(
  parameter int SBOX_LANES = 1,
  parameter int MIX_LANES  = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        sub,
  input  logic        enc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic [31:0] rd
);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_sbox_lanes
    $error("aes_v3_multicycle: SBOX_LANES must be 1, 2 or 4");
  end
  if (!(MIX_LANES == 1 || MIX_LANES == 2 || MIX_LANES == 4)) begin : g_bad_mix_lanes
    $error("aes_v3_multicycle: MIX_LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] res_q, res_d;
  // Only the operand bytes either operation can consume are latched.
  logic [23:0] rs1_q;
  logic [31:8] rs2_q;
  logic        sub_q, enc_q;
  logic [1:0]  last_step;
  logic        unused_ok;

  logic [7:0]  sb_src [4];
  logic [7:0]  mx_src [4];
  logic [1:0]  sb_idx [SBOX_LANES];
  logic [7:0]  sb_out [SBOX_LANES];
  logic [1:0]  mx_idx [MIX_LANES];
  logic [7:0]  mx_out [MIX_LANES];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] t;
    t = gf_inv(a);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_V3_DECRYPT_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
`endif

  assign unused_ok = ^{rs1[31:24], rs2[7:0]};

  assign sb_src[0] = rs1_q[7:0];
  assign sb_src[1] = rs2_q[15:8];
  assign sb_src[2] = rs1_q[23:16];
  assign sb_src[3] = rs2_q[31:24];
  assign mx_src[0] = rs1_q[7:0];
  assign mx_src[1] = rs1_q[15:8];
  assign mx_src[2] = rs2_q[23:16];
  assign mx_src[3] = rs2_q[31:24];

  assign last_step = sub_q ? 2'(4 / SBOX_LANES - 1) : 2'(4 / MIX_LANES - 1);

  for (genvar gi = 0; gi < SBOX_LANES; gi++) begin : g_sbox
    logic [7:0] b;
    assign sb_idx[gi] = 2'(int'(step_q) * SBOX_LANES + gi);
    assign b          = sb_src[sb_idx[gi]];
`ifdef AES_V3_DECRYPT_EN
    assign sb_out[gi] = enc_q ? sbox_fwd(b) : sbox_inv(b);
`else
    assign sb_out[gi] = enc_q ? sbox_fwd(b) : 8'h00;
`endif
  end

  for (genvar gi = 0; gi < MIX_LANES; gi++) begin : g_mix
    logic [1:0] i1, i2, i3;
    logic [7:0] m0, m1, m2, m3;
    assign mx_idx[gi] = 2'(int'(step_q) * MIX_LANES + gi);
    assign i1 = mx_idx[gi] + 2'd1;
    assign i2 = mx_idx[gi] + 2'd2;
    assign i3 = mx_idx[gi] + 2'd3;
    assign m0 = mx_src[mx_idx[gi]];
    assign m1 = mx_src[i1];
    assign m2 = mx_src[i2];
    assign m3 = mx_src[i3];
`ifdef AES_V3_DECRYPT_EN
    assign mx_out[gi] = enc_q ? (gf_mul(8'h02, m0) ^ gf_mul(8'h03, m1) ^ m2 ^ m3)
                              : (gf_mul(8'h0e, m0) ^ gf_mul(8'h0b, m1) ^
                                 gf_mul(8'h0d, m2) ^ gf_mul(8'h09, m3));
`else
    assign mx_out[gi] = enc_q ? (gf_mul(8'h02, m0) ^ gf_mul(8'h03, m1) ^ m2 ^ m3) : 8'h00;
`endif
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_BUSY;
          step_d  = '0;
          res_d   = '0;
        end
      end
      ST_BUSY: begin
        if (!valid) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else begin
          if (sub_q) begin
            for (int l = 0; l < SBOX_LANES; l++) res_d[{sb_idx[l], 3'b000} +: 8] = sb_out[l];
          end else begin
            for (int l = 0; l < MIX_LANES; l++) res_d[{mx_idx[l], 3'b000} +: 8] = mx_out[l];
          end
          if (step_q == last_step) begin
            state_d = ST_DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      res_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      sub_q   <= 1'b0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      res_q   <= res_d;
      if (state_q == ST_IDLE && valid) begin
        rs1_q <= rs1[23:0];
        rs2_q <= rs2[31:8];
        sub_q <= sub;
        enc_q <= enc;
      end
    end
  end

  assign ready = (state_q == ST_DONE);
  assign rd    = ready ? res_q : 32'h0;

endmodule

// File: tb/tb_aes_v3_multicycle.sv
// Scoreboard bench for aes_v3_multicycle: fixed AES vectors, random ops against a table model,
// abort, operand hold, back-to-back and mid-operation reset.
module tb_aes_v3_multicycle #(
  parameter int SBOX_LANES = 1,
  parameter int MIX_LANES  = 1
);

  localparam int SUB_LAT = 1 + 4 / SBOX_LANES;
  localparam int MIX_LAT = 1 + 4 / MIX_LANES;
`ifdef AES_V3_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic        g_clk;
  logic        g_resetn;
  logic        valid;
  logic        sub;
  logic        enc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready;
  logic [31:0] rd;

  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_q [$];
  logic [7:0]  sbox_t  [256];
  logic [7:0]  isbox_t [256];

  aes_v3_multicycle #(
    .SBOX_LANES(SBOX_LANES),
    .MIX_LANES (MIX_LANES)
  ) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .valid   (valid),
    .sub     (sub),
    .enc     (enc),
    .rs1     (rs1),
    .rs2     (rs2),
    .ready   (ready),
    .rd      (rd)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Model multiply: carry-less product, then polynomial reduction by 0x11b.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, x8;
    for (int x = 0; x < 256; x++) begin
      x8  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(x8, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
      s = s ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = x8;
    end
  endtask

  function automatic logic [31:0] m_sub(input logic e, input logic [31:0] a, input logic [31:0] b);
    logic [7:0] src [4];
    logic [7:0] o [4];
    src[0] = a[7:0]; src[1] = b[15:8]; src[2] = a[23:16]; src[3] = b[31:24];
    for (int i = 0; i < 4; i++) o[i] = e ? sbox_t[src[i]] : (DEC_EN ? isbox_t[src[i]] : 8'h00);
    return {o[3], o[2], o[1], o[0]};
  endfunction

  function automatic logic [31:0] m_mix(input logic e, input logic [31:0] a, input logic [31:0] b);
    logic [7:0] m [4];
    logic [7:0] c [4];
    logic [7:0] o [4];
    m[0] = a[7:0]; m[1] = a[15:8]; m[2] = b[23:16]; m[3] = b[31:24];
    if (e) begin c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01; end
    else   begin c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09; end
    for (int i = 0; i < 4; i++) begin
      o[i] = 8'h00;
      for (int j = 0; j < 4; j++) o[i] ^= m_mul(c[j], m[(i + j) % 4]);
    end
    if (!e && !DEC_EN) return 32'h0;
    return {o[3], o[2], o[1], o[0]};
  endfunction

  // Drives one request from an IDLE-or-DONE cycle and waits (bounded) for ready.
  // lat counts edges from the first edge after driving, -1 on timeout; leak flags nonzero rd while ready=0.
  task automatic issue(input logic s, input logic e, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit hold, input bit scramble,
                       output int lat, output logic [31:0] got, output bit leak);
    int n;
    exp_q.push_back(expv);
    sub = s; enc = e; rs1 = a; rs2 = b; valid = 1'b1;
    lat = -1; got = '0; leak = 1'b0; n = 0;
    while (n < 40 && lat < 0) begin
      @(posedge g_clk); #1;
      n++;
      if (scramble && n == 1) begin
        rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; sub = ~s; enc = ~e;
      end
      if (ready === 1'b1) begin
        lat = n;
        got = rd;
      end else if (rd !== 32'h0) begin
        leak = 1'b1;
      end
    end
    if (!hold) valid = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0; valid = 1'b0; sub = 1'b0; enc = 1'b0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge g_clk);
    #1;
    valid = 1'b1; sub = 1'b1; enc = 1'b1; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
    @(posedge g_clk); #1;
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0", ready); end
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_rd got=%h exp=00000000", rd); end
    valid = 1'b0;
    g_resetn = 1'b1;
    repeat (6) begin
      @(posedge g_clk); #1;
      tests_run++;
      if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_ready got=%b exp=0", ready); end
    end
    $display("[TB] reset done ready=%b rd=%h", ready, rd);
  endtask

  task automatic test_vectors();
    logic [31:0] got, expv;
    int          lat;
    bit          leak;
    logic        vs [4];
    logic        ve [4];
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vx [4];
    vs[0] = 1'b1; ve[0] = 1'b1; va[0] = 32'h00530000; vb[0] = 32'h00000000; vx[0] = 32'h63ED6363;
    vs[1] = 1'b1; ve[1] = 1'b0; va[1] = 32'h00ED0063; vb[1] = 32'h63006300;
    vx[1] = DEC_EN ? 32'h00530000 : 32'h0;
    vs[2] = 1'b0; ve[2] = 1'b1; va[2] = 32'h000013DB; vb[2] = 32'h45530000; vx[2] = 32'hBCA14D8E;
    vs[3] = 1'b0; ve[3] = 1'b0; va[3] = 32'h00004D8E; vb[3] = 32'hBCA10000;
    vx[3] = DEC_EN ? 32'h455313DB : 32'h0;
    for (int v = 0; v < 4; v++) begin
      issue(vs[v], ve[v], va[v], vb[v], vx[v], 1'b0, 1'b0, lat, got, leak);
      expv = exp_q.pop_front();
      tests_run++;
      if (got !== expv) begin tests_failed++; $display("FAIL vec%0d_rd got=%h exp=%h", v, got, expv); end
      tests_run++;
      if (lat !== (vs[v] ? SUB_LAT : MIX_LAT)) begin
        tests_failed++; $display("FAIL vec%0d_latency got=%0d exp=%0d", v, lat, vs[v] ? SUB_LAT : MIX_LAT);
      end
      tests_run++;
      if (leak !== 1'b0) begin tests_failed++; $display("FAIL vec%0d_rd_leak got=%b exp=0", v, leak); end
      @(posedge g_clk); #1;
      tests_run++;
      if (ready !== 1'b0) begin tests_failed++; $display("FAIL vec%0d_pulse got=%b exp=0", v, ready); end
      $display("[TB] vec%0d sub=%b enc=%b rs1=%h rs2=%h rd=%h lat=%0d", v, vs[v], ve[v], va[v], vb[v], got, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, expv, a, b;
    logic        s, e;
    int          lat;
    bit          leak;
    for (int t = 0; t < 12; t++) begin
      s = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      issue(s, e, a, b, s ? m_sub(e, a, b) : m_mix(e, a, b), 1'b0, 1'b0, lat, got, leak);
      expv = exp_q.pop_front();
      tests_run++;
      if (got !== expv) begin tests_failed++; $display("FAIL rand%0d_rd got=%h exp=%h", t, got, expv); end
      tests_run++;
      if (lat !== (s ? SUB_LAT : MIX_LAT)) begin
        tests_failed++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, s ? SUB_LAT : MIX_LAT);
      end
      tests_run++;
      if (leak !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_rd_leak got=%b exp=0", t, leak); end
      @(posedge g_clk); #1;
      $display("[TB] rand%0d sub=%b enc=%b rs1=%h rs2=%h rd=%h lat=%0d", t, s, e, a, b, got, lat);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got, expv;
    int          lat, pulses;
    bit          leak;
    valid = 1'b1; sub = 1'b0; enc = 1'b1; rs1 = 32'h000013DB; rs2 = 32'h45530000;
    @(posedge g_clk); #1;
    if (MIX_LANES < 4) begin
      @(posedge g_clk); #1;
    end
    valid = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge g_clk); #1;
      if (ready === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL abort_no_ready got=%0d exp=0", pulses); end
    issue(1'b1, 1'b1, 32'h00530000, 32'h0, 32'h63ED6363, 1'b0, 1'b0, lat, got, leak);
    expv = exp_q.pop_front();
    tests_run++;
    if (got !== expv) begin tests_failed++; $display("FAIL abort_reissue_rd got=%h exp=%h", got, expv); end
    tests_run++;
    if (lat !== SUB_LAT) begin tests_failed++; $display("FAIL abort_reissue_latency got=%0d exp=%0d", lat, SUB_LAT); end
    @(posedge g_clk); #1;
    $display("[TB] abort pulses=%0d reissue rd=%h lat=%0d", pulses, got, lat);
  endtask

  task automatic test_operand_hold();
    logic [31:0] got, expv;
    int          lat;
    bit          leak;
    issue(1'b1, 1'b1, 32'h00530000, 32'h0, 32'h63ED6363, 1'b0, 1'b1, lat, got, leak);
    expv = exp_q.pop_front();
    tests_run++;
    if (got !== expv) begin tests_failed++; $display("FAIL hold_rd got=%h exp=%h", got, expv); end
    tests_run++;
    if (lat !== SUB_LAT) begin tests_failed++; $display("FAIL hold_latency got=%0d exp=%0d", lat, SUB_LAT); end
    tests_run++;
    if (leak !== 1'b0) begin tests_failed++; $display("FAIL hold_rd_leak got=%b exp=0", leak); end
    @(posedge g_clk); #1;
    $display("[TB] operand_hold rd=%h lat=%0d", got, lat);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, expv;
    int          lat;
    bit          leak;
    issue(1'b0, 1'b1, 32'h000013DB, 32'h45530000, 32'hBCA14D8E, 1'b1, 1'b0, lat, got, leak);
    expv = exp_q.pop_front();
    tests_run++;
    if (got !== expv) begin tests_failed++; $display("FAIL b2b_first_rd got=%h exp=%h", got, expv); end
    issue(1'b1, 1'b1, 32'h00530000, 32'h0, 32'h63ED6363, 1'b0, 1'b0, lat, got, leak);
    expv = exp_q.pop_front();
    tests_run++;
    if (got !== expv) begin tests_failed++; $display("FAIL b2b_second_rd got=%h exp=%h", got, expv); end
    tests_run++;
    if (lat !== SUB_LAT + 1) begin tests_failed++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, SUB_LAT + 1); end
    @(posedge g_clk); #1;
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_pulse got=%b exp=0", ready); end
    $display("[TB] back_to_back second rd=%h lat=%0d", got, lat);
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, expv;
    int          lat, pulses;
    bit          leak;
    valid = 1'b1; sub = 1'b1; enc = 1'b1; rs1 = 32'h00530000; rs2 = 32'h0;
    @(posedge g_clk); #1;
    g_resetn = 1'b0; valid = 1'b0;
    @(posedge g_clk); #1;
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_ready got=%b exp=0", ready); end
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL midreset_rd got=%h exp=00000000", rd); end
    g_resetn = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge g_clk); #1;
      if (ready === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL midreset_no_ready got=%0d exp=0", pulses); end
    issue(1'b0, 1'b1, 32'h000013DB, 32'h45530000, 32'hBCA14D8E, 1'b0, 1'b0, lat, got, leak);
    expv = exp_q.pop_front();
    tests_run++;
    if (got !== expv) begin tests_failed++; $display("FAIL midreset_next_rd got=%h exp=%h", got, expv); end
    tests_run++;
    if (lat !== MIX_LAT) begin tests_failed++; $display("FAIL midreset_next_latency got=%0d exp=%0d", lat, MIX_LAT); end
    @(posedge g_clk); #1;
    $display("[TB] reset_mid pulses=%0d next rd=%h lat=%0d", pulses, got, lat);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    build_tables();
    test_reset();
    test_vectors();
    test_random();
    test_abort();
    test_operand_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
